// File: rtl/sram_result_pkg.sv
// Shared types and default sizes for the result SRAM block.
package sram_result_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 7;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_result_core.sv
// Single-port word storage: one synchronous write per cycle, combinational read of the addressed word.
module sram_result_core
    import sram_result_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Wr_Data,
    output logic [DATA_W-1:0] Rd_Data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array; the owner clears it by sweeping writes.
    always_ff @(posedge Clk) begin
        if (Wr_En) begin
            mem[Addr] <= Wr_Data;
        end
    end

    assign Rd_Data = mem[Addr];

endmodule

// File: rtl/sram_result_param.sv
// Result SRAM with a reset/Clr-triggered zeroing sweep and registered reads.
// Optional minimum-write tracker enabled by defining SRAM_RESULT_MIN_TRACK_EN.
module sram_result_param
    import sram_result_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              Clr,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Rd_Valid,
    output logic              Busy
`ifdef SRAM_RESULT_MIN_TRACK_EN
    ,
    output logic [DATA_W-1:0] Min_Val,
    output logic [ADDR_W-1:0] Min_Addr,
    output logic              Min_Valid
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, next_state;
    logic [ADDR_W-1:0] cnt;
    logic              user_wr, user_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    // Clr outranks any user access presented in the same cycle.
    assign user_wr = (state == IDLE) && !Clr && En && RW;
    assign user_rd = (state == IDLE) && !Clr && En && !RW;

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_addr   = Addr;
        mem_wdata  = Data_In;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
                if (cnt == LAST_ADDR) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                mem_we = user_wr;
                if (Clr) begin
                    next_state = CLEAR;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR && cnt != LAST_ADDR) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Data_Out <= '0;
            Rd_Valid <= 1'b0;
        end else begin
            Rd_Valid <= user_rd;
            if (user_rd) begin
                Data_Out <= mem_rdata;
            end
        end
    end

    assign Busy = (state == CLEAR);

    sram_result_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .Clk     (Clk),
        .Wr_En   (mem_we),
        .Addr    (mem_addr),
        .Wr_Data (mem_wdata),
        .Rd_Data (mem_rdata)
    );

`ifdef SRAM_RESULT_MIN_TRACK_EN
    // Strict unsigned compare so the earliest of equal minima is kept.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Min_Valid <= 1'b0;
            Min_Val   <= '1;
            Min_Addr  <= '0;
        end else if (state == IDLE && Clr) begin
            Min_Valid <= 1'b0;
            Min_Val   <= '1;
            Min_Addr  <= '0;
        end else if (user_wr && (!Min_Valid || Data_In < Min_Val)) begin
            Min_Valid <= 1'b1;
            Min_Val   <= Data_In;
            Min_Addr  <= Addr;
        end
    end
`endif

endmodule

// File: tb/tb_sram_result_param.sv
// Scoreboard bench for sram_result_param: default-size instance plus a 16x16 instance.
module tb_sram_result_param;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int S_DW  = 16;
    localparam int S_AW  = 4;
    localparam int S_DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          En, RW, Clr;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Data_In, Data_Out;
    logic          Rd_Valid, Busy;

    logic            s_en, s_rw, s_clr;
    logic [S_AW-1:0] s_addr;
    logic [S_DW-1:0] s_din, s_dout;
    logic            s_rv, s_busy;

`ifdef SRAM_RESULT_MIN_TRACK_EN
    logic [DW-1:0]   Min_Val;
    logic [AW-1:0]   Min_Addr;
    logic            Min_Valid;
    logic [S_DW-1:0] s_min_val;
    logic [S_AW-1:0] s_min_addr;
    logic            s_min_valid;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   model_mem [DEPTH];
    logic [DW-1:0]   exp_q [$];
    logic [S_DW-1:0] s_exp_q [$];

    always #5 Clk = ~Clk;

    sram_result_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .En       (En),
        .RW       (RW),
        .Addr     (Addr),
        .Data_In  (Data_In),
        .Clr      (Clr),
        .Data_Out (Data_Out),
        .Rd_Valid (Rd_Valid),
        .Busy     (Busy)
`ifdef SRAM_RESULT_MIN_TRACK_EN
        ,
        .Min_Val  (Min_Val),
        .Min_Addr (Min_Addr),
        .Min_Valid(Min_Valid)
`endif
    );

    sram_result_param #(.DATA_W(S_DW), .ADDR_W(S_AW)) dut_small (
        .Clk      (Clk),
        .Rst      (Rst),
        .En       (s_en),
        .RW       (s_rw),
        .Addr     (s_addr),
        .Data_In  (s_din),
        .Clr      (s_clr),
        .Data_Out (s_dout),
        .Rd_Valid (s_rv),
        .Busy     (s_busy)
`ifdef SRAM_RESULT_MIN_TRACK_EN
        ,
        .Min_Val  (s_min_val),
        .Min_Addr (s_min_addr),
        .Min_Valid(s_min_valid)
`endif
    );

    // Every read-valid pulse must match the oldest outstanding expected word.
    always @(negedge Clk) begin
        if (!Rst && Rd_Valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rd_unexpected: Rd_Valid=1 Data_Out=%h, required no read", Data_Out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (Data_Out !== e) begin
                    errors++;
                    $display("[TB] FAIL rd_data: Data_Out=%h required %h", Data_Out, e);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (!Rst && s_rv) begin
            checks++;
            if (s_exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL small_rd_unexpected: s_dout=%h, required no read", s_dout);
            end else begin
                logic [S_DW-1:0] e;
                e = s_exp_q.pop_front();
                if (s_dout !== e) begin
                    errors++;
                    $display("[TB] FAIL small_rd_data: s_dout=%h required %h", s_dout, e);
                end
            end
        end
    end

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        En = 1'b1; RW = 1'b1; Addr = a; Data_In = d;
        model_mem[a] = d;
        @(negedge Clk);
        En = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        En = 1'b1; RW = 1'b0; Addr = a;
        exp_q.push_back(model_mem[a]);
        @(negedge Clk);
        En = 1'b0;
    endtask

    task automatic measure_busy(output int n_big, output int n_small);
        n_big = 0;
        n_small = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!Busy && !s_busy) break;
            if (Busy) n_big++;
            if (s_busy) n_small++;
            @(negedge Clk);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 10 && (exp_q.size() != 0 || s_exp_q.size() != 0); i++) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0 || s_exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: outstanding reads big=%0d small=%0d, required 0", exp_q.size(), s_exp_q.size());
        end
    endtask

    task automatic test_reset();
        int nb, ns;
        Rst = 1'b1;
        En = 0; RW = 0; Clr = 0; Addr = '0; Data_In = '0;
        s_en = 0; s_rw = 0; s_clr = 0; s_addr = '0; s_din = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1 || Rd_Valid !== 1'b0 || Data_Out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: Busy=%b Rd_Valid=%b Data_Out=%h required 1 0 0", Busy, Rd_Valid, Data_Out);
        end
        Rst = 1'b0;
        measure_busy(nb, ns);
        checks++;
        if (nb != DEPTH) begin
            errors++;
            $display("[TB] FAIL busy_after_reset: %0d cycles required %0d", nb, DEPTH);
        end
        checks++;
        if (ns != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL small_busy_after_reset: %0d cycles required %0d", ns, S_DEPTH);
        end
        zero_model();
    endtask

    task automatic test_read_after_sweep();
        do_read(7'h7F);
        @(negedge Clk);
        checks++;
        if (Rd_Valid !== 1'b0 || Data_Out !== '0) begin
            errors++;
            $display("[TB] FAIL single_pulse_0x7f: Rd_Valid=%b Data_Out=%h required 0 0", Rd_Valid, Data_Out);
        end
        wait_drain();
    endtask

    task automatic test_write_read();
        do_write(7'h05, 32'hDEADBEEF);
        checks++;
        if (Rd_Valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_no_valid: Rd_Valid=%b required 0", Rd_Valid);
        end
        do_read(7'h05);
        repeat (2) @(negedge Clk);
        checks++;
        if (Rd_Valid !== 1'b0 || Data_Out !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL hold_after_read: Rd_Valid=%b Data_Out=%h required 0 deadbeef", Rd_Valid, Data_Out);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 8; i++) do_write(AW'(8'h20 + i), $urandom());
        for (int i = 0; i < 8; i++) begin
            En = 1'b1; RW = 1'b0; Addr = AW'(8'h20 + i);
            exp_q.push_back(model_mem[8'h20 + i]);
            @(negedge Clk);
            if (Rd_Valid) pulses++;
        end
        En = 1'b0;
        @(negedge Clk);
        checks++;
        if (pulses != 8 || Rd_Valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_back: pulses=%0d tail_valid=%b required 8 0", pulses, Rd_Valid);
        end
        wait_drain();
    endtask

    task automatic test_clear_drop();
        int n = 0;
        bit rv_seen = 0;
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!Busy) break;
            n++;
            if (n == 40) begin En = 1; RW = 1; Addr = 7'h10; Data_In = 32'hCAFEF00D; end
            if (n == 41) begin En = 1; RW = 0; Addr = 7'h10; end
            if (n == 42) En = 0;
            if (n == 60) Clr = 1;
            if (n == 61) Clr = 0;
            @(negedge Clk);
            if (Rd_Valid) rv_seen = 1;
        end
        En = 0; Clr = 0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("[TB] FAIL busy_clr_ignored: %0d cycles required %0d", n, DEPTH);
        end
        checks++;
        if (rv_seen) begin
            errors++;
            $display("[TB] FAIL read_during_busy: Rd_Valid seen=1 required 0");
        end
        zero_model();
        do_read(7'h10);
        do_read(7'h05);
        wait_drain();
    endtask

    task automatic test_clr_priority();
        int nb, ns;
        Clr = 1; En = 1; RW = 0; Addr = 7'h05;
        @(negedge Clk);
        Clr = 0; En = 0;
        checks++;
        if (Rd_Valid !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_priority: Rd_Valid=%b Busy=%b required 0 1", Rd_Valid, Busy);
        end
        measure_busy(nb, ns);
        checks++;
        if (nb != DEPTH) begin
            errors++;
            $display("[TB] FAIL busy_after_clr: %0d cycles required %0d", nb, DEPTH);
        end
        zero_model();
    endtask

    task automatic test_reset_mid_sweep();
        int nb, ns;
        do_write(7'h7F, 32'hA5A5A5A5);
        do_read(7'h7F);
        wait_drain();
        Clr = 1;
        @(negedge Clk);
        Clr = 0;
        repeat (50) @(negedge Clk);
        Rst = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b1 || Data_Out !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: Busy=%b Data_Out=%h required 1 0", Busy, Data_Out);
        end
        @(negedge Clk);
        Rst = 1'b0;
        measure_busy(nb, ns);
        checks++;
        if (nb != DEPTH || ns != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL sweep_restart: big=%0d small=%0d required %0d %0d", nb, ns, DEPTH, S_DEPTH);
        end
        zero_model();
        do_read(7'h7F);
        wait_drain();
    endtask

    task automatic test_small_back_to_back();
        int pulses = 0;
        logic [S_DW-1:0] vals [S_DEPTH];
        for (int i = 0; i < S_DEPTH; i++) begin
            vals[i] = S_DW'(16'h1000 + i * 16'h0111);
            s_en = 1; s_rw = 1; s_addr = S_AW'(i); s_din = vals[i];
            @(negedge Clk);
        end
        for (int i = 0; i < S_DEPTH; i++) begin
            s_en = 1; s_rw = 0; s_addr = S_AW'(i);
            s_exp_q.push_back(vals[i]);
            @(negedge Clk);
            if (s_rv) pulses++;
        end
        s_en = 0;
        @(negedge Clk);
        checks++;
        if (pulses != S_DEPTH || s_rv !== 1'b0) begin
            errors++;
            $display("[TB] FAIL small_back_to_back: pulses=%0d tail_valid=%b required %0d 0", pulses, s_rv, S_DEPTH);
        end
        wait_drain();
    endtask

`ifdef SRAM_RESULT_MIN_TRACK_EN
    task automatic test_min_track();
        int nb, ns;
        checks++;
        if (Min_Valid !== 1'b0 || Min_Val !== '1 || Min_Addr !== '0) begin
            errors++;
            $display("[TB] FAIL min_after_reset: V=%b Val=%h A=%h required 0 ffffffff 00", Min_Valid, Min_Val, Min_Addr);
        end
        do_write(7'h01, 32'd300);
        do_write(7'h02, 32'd120);
        do_write(7'h03, 32'd120);
        do_write(7'h04, 32'd500);
        checks++;
        if (Min_Valid !== 1'b1 || Min_Val !== 32'd120 || Min_Addr !== 7'h02) begin
            errors++;
            $display("[TB] FAIL min_track: V=%b Val=%0d A=%h required 1 120 02", Min_Valid, Min_Val, Min_Addr);
        end
        Clr = 1;
        @(negedge Clk);
        Clr = 0;
        checks++;
        if (Min_Valid !== 1'b0 || Min_Val !== '1 || Min_Addr !== '0) begin
            errors++;
            $display("[TB] FAIL min_after_clr: V=%b Val=%h A=%h required 0 ffffffff 00", Min_Valid, Min_Val, Min_Addr);
        end
        measure_busy(nb, ns);
        zero_model();
    endtask
`endif

    initial begin
        test_reset();
`ifdef SRAM_RESULT_MIN_TRACK_EN
        test_min_track();
`endif
        test_read_after_sweep();
        test_write_read();
        test_back_to_back();
        test_clear_drop();
        test_clr_priority();
        test_reset_mid_sweep();
        test_small_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_result_param.md
SRAM_RESULT_PARAM -- requirements
Module: sram_result_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result word width in bits (legal range 8..64).
REQ-002 SHALL have parameter ADDR_W, default 7, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port Rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port En  input  1  access enable.
REQ-006 SHALL have port RW  input  1  1 = write, 0 = read; qualified by En.
REQ-007 SHALL have port Addr  input  ADDR_W  word address.
REQ-008 SHALL have port Data_In  input  DATA_W  write data.
REQ-009 SHALL have port Clr  input  1  single-cycle pulse that requests a full-memory clear.
REQ-010 SHALL have port Data_Out  output  DATA_W  registered read data.
REQ-011 SHALL have port Rd_Valid  output  1  high for exactly one cycle when Data_Out holds new read data.
REQ-012 SHALL have port Busy  output  1  high while the clear sweep is in progress.
REQ-013 SHALL have, with SRAM_RESULT_MIN_TRACK_EN only, ports Min_Val (output, DATA_W), Min_Addr (output, ADDR_W) and Min_Valid (output, 1).

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and IDLE.
REQ-015 In CLEAR, SHALL write 0 to Memory[cnt] each cycle, with cnt incrementing from 0; at cnt == DEPTH-1 SHALL enter IDLE, so Busy is high for exactly DEPTH cycles.
REQ-016 In IDLE, Clr = 1 SHALL enter CLEAR with cnt = 0 on the next edge; Clr during CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-017 In IDLE, En = 1 with RW = 1 SHALL write Data_In to Memory[Addr].
REQ-018 In IDLE, En = 1 with RW = 0 SHALL load Data_Out with Memory[Addr] and assert Rd_Valid on that edge (1-cycle latency); Data_Out SHALL hold its value otherwise.
REQ-019 Back-to-back reads SHALL give one Rd_Valid pulse per read with no bubbles.
REQ-020 A read of an address written on the previous edge SHALL return the new data; no same-cycle write-through.
REQ-021 In CLEAR, or when Clr and En are both high in IDLE, user accesses SHALL be dropped: no write, Rd_Valid = 0; Clr takes priority.
REQ-022 Address arithmetic SHALL be unsigned modulo DEPTH; cnt SHALL NOT wrap past DEPTH-1.

Reset
REQ-023 Rst SHALL asynchronously force Data_Out = 0, Rd_Valid = 0, cnt = 0, FSM = CLEAR and Busy = 1.
REQ-024 The clear sweep SHALL start at the first edge after Rst deasserts, so memory is all-zero DEPTH cycles after reset.
REQ-025 Rst asserted mid-sweep or mid-access SHALL abort the operation and restart the sweep from address 0.
REQ-026 Memory contents SHALL NOT be asynchronously reset; only the sweep clears them.

Configuration
REQ-027 Macro SRAM_RESULT_MIN_TRACK_EN, when defined, SHALL make each accepted write with Data_In < Min_Val, or with Min_Valid = 0, set Min_Val = Data_In, Min_Addr = Addr and Min_Valid = 1 on the next edge.
REQ-028 With the macro, comparison SHALL be unsigned and strict, so the earliest write wins a tie.
REQ-029 With the macro, Rst and entry to CLEAR SHALL set Min_Valid = 0, Min_Val = all ones and Min_Addr = 0.
REQ-030 Without the macro, the Min_* ports and tracking logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package sram_result_pkg SHALL hold the FSM state typedef (CLEAR, IDLE) and the default DATA_W and ADDR_W constants.
REQ-032 Storage SHALL be a sub-module sram_result_core: single-port, one write or read per cycle, parametrised by DATA_W and ADDR_W.
REQ-033 The FSM, clear counter and min tracker SHALL reside in sram_result_param.

Verification
REQ-034 Release Rst, then poll -> Busy high for exactly 128 cycles; then a read at 0x7F -> Data_Out = 0, Rd_Valid = 1 for one cycle.
REQ-035 Write 0xDEADBEEF to 0x05, then read 0x05 on the next cycle -> one cycle later Data_Out = 0xDEADBEEF with a single Rd_Valid pulse.
REQ-036 Pulse Clr, then attempt a write to 0x10 during Busy -> write is dropped; a read of 0x10 after Busy falls returns 0.
REQ-037 Assert Rst at sweep cycle 50 -> Busy stays high, and the sweep restarts and runs 128 cycles after release.
REQ-038 With the macro, write 300@0x01, 120@0x02, 120@0x03, 500@0x04 -> Min_Val = 120, Min_Addr = 0x02, Min_Valid = 1; after Clr -> Min_Valid = 0.
REQ-039 With DATA_W = 16 and ADDR_W = 4, read 16 addresses back to back -> 16 consecutive Rd_Valid pulses, and Busy lasts 16 cycles after reset.
